// File: rtl/bus_display_rx.sv
// Tagged-word receiver for the CPU data bus: sequence checking, 14-bit binary to BCD
// conversion and an 8-digit multiplexed seven-segment display driver.
module bus_display_rx #(
    parameter logic [7:0]  TAG         = 8'hAC,
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataBus,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        data_valid,
    output logic        seq_err,
    output logic [7:0]  rx_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [2:0] TYPE_CLEAR = 3'b111;
    localparam logic [3:0] LAST_STEP  = 4'd13;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] code;
        case (v)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            4'hF:    code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Add-3 correction applied to every BCD nibble of 5 or more before each shift.
    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    logic [31:0] bus_q_r;
    logic [6:0]  last_seq_r;
    logic        got_first_r;
    logic [7:0]  rx_count_r;
    logic        seq_err_r;

    logic [1:0]  state_r;
    logic [13:0] conv_bin_r;
    logic [19:0] conv_bcd_r;
    logic [6:0]  conv_seq_r;
    logic [3:0]  step_r;
    logic        pend_valid_r;
    logic [13:0] pend_data_r;
    logic [6:0]  pend_seq_r;
    logic        clr_load_r;

    logic [19:0] disp_bcd_r;
    logic [6:0]  disp_seq_r;
    logic        data_valid_r;

    logic [15:0] scan_cnt_r;
    logic [2:0]  digit_idx_r;
    logic [7:0]  an_r;
    logic [7:0]  seg_r;

    logic [7:0]  tag_s;
    logic [6:0]  seq_s;
    logic [2:0]  type_s;
    logic [13:0] data_s;
    logic [6:0]  seq_next_s;
    logic        accept_s;
    logic        clear_s;
    logic        data_acc_s;
    logic        gap_s;
    logic [19:0] adj_s;
    logic [7:0]  digit_code_s;
    logic [7:0]  an_code_s;

    // Field split and accept decision on the registered bus word.
    always_comb begin
        tag_s      = bus_q_r[31:24];
        seq_s      = bus_q_r[23:17];
        type_s     = bus_q_r[16:14];
        data_s     = bus_q_r[13:0];
        seq_next_s = last_seq_r + 7'd1;
        accept_s   = (tag_s == TAG) && (!got_first_r || (seq_s != last_seq_r));
        clear_s    = accept_s && (type_s == TYPE_CLEAR);
        data_acc_s = accept_s && (type_s != TYPE_CLEAR);
        gap_s      = got_first_r && (seq_s != seq_next_s);
        adj_s      = dd_adjust(conv_bcd_r);
    end

    // Input capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q_r <= 32'h0000_0000;
        end else begin
            bus_q_r <= dataBus;
        end
    end

    // Accept bookkeeping: last sequence number, receive counter, sticky gap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seq_r  <= 7'd0;
            got_first_r <= 1'b0;
            rx_count_r  <= 8'd0;
            seq_err_r   <= 1'b0;
        end else if (accept_s) begin
            last_seq_r  <= seq_s;
            got_first_r <= 1'b1;
            rx_count_r  <= rx_count_r + 8'd1;
            if (clear_s) begin
                seq_err_r <= 1'b0;
            end else if (gap_s) begin
                seq_err_r <= 1'b1;
            end else begin
                seq_err_r <= seq_err_r;
            end
        end else begin
            last_seq_r  <= last_seq_r;
            got_first_r <= got_first_r;
            rx_count_r  <= rx_count_r;
            seq_err_r   <= seq_err_r;
        end
    end

    // Converter FSM, one-deep pending slot and display value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            conv_bin_r   <= 14'd0;
            conv_bcd_r   <= 20'd0;
            conv_seq_r   <= 7'd0;
            step_r       <= 4'd0;
            pend_valid_r <= 1'b0;
            pend_data_r  <= 14'd0;
            pend_seq_r   <= 7'd0;
            clr_load_r   <= 1'b0;
            disp_bcd_r   <= 20'd0;
            disp_seq_r   <= 7'd0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            clr_load_r   <= clear_s;
            // A clear blanks the display one cycle after it is accepted.
            if (clr_load_r) begin
                disp_bcd_r   <= 20'd0;
                disp_seq_r   <= 7'd0;
                data_valid_r <= 1'b1;
            end
            if (clear_s) begin
                state_r      <= ST_IDLE;
                pend_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (data_acc_s) begin
                            conv_bin_r <= data_s;
                            conv_bcd_r <= 20'd0;
                            conv_seq_r <= seq_s;
                            step_r     <= 4'd0;
                            state_r    <= ST_CONV;
                        end
                    end
                    ST_CONV: begin
                        conv_bcd_r <= {adj_s[18:0], conv_bin_r[13]};
                        conv_bin_r <= {conv_bin_r[12:0], 1'b0};
                        step_r     <= step_r + 4'd1;
                        if (step_r == LAST_STEP) begin
                            state_r <= ST_LOAD;
                        end
                        if (data_acc_s) begin
                            pend_valid_r <= 1'b1;
                            pend_data_r  <= data_s;
                            pend_seq_r   <= seq_s;
                        end
                    end
                    ST_LOAD: begin
                        disp_bcd_r   <= conv_bcd_r;
                        disp_seq_r   <= conv_seq_r;
                        data_valid_r <= 1'b1;
                        step_r       <= 4'd0;
                        conv_bcd_r   <= 20'd0;
                        if (pend_valid_r) begin
                            conv_bin_r <= pend_data_r;
                            conv_seq_r <= pend_seq_r;
                            state_r    <= ST_CONV;
                            if (data_acc_s) begin
                                pend_data_r <= data_s;
                                pend_seq_r  <= seq_s;
                            end else begin
                                pend_valid_r <= 1'b0;
                            end
                        end else if (data_acc_s) begin
                            conv_bin_r <= data_s;
                            conv_seq_r <= seq_s;
                            state_r    <= ST_CONV;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        an_code_s = ~(8'b0000_0001 << digit_idx_r);
        case (digit_idx_r)
            3'd0:    digit_code_s = seg7(disp_bcd_r[3:0]);
            3'd1:    digit_code_s = seg7(disp_bcd_r[7:4]);
            3'd2:    digit_code_s = seg7(disp_bcd_r[11:8]);
            3'd3:    digit_code_s = seg7(disp_bcd_r[15:12]);
            3'd4:    digit_code_s = seg7(disp_bcd_r[19:16]);
            3'd5:    digit_code_s = 8'hFF;
            3'd6:    digit_code_s = seg7(disp_seq_r[3:0]);
            3'd7:    digit_code_s = seg7({1'b0, disp_seq_r[6:4]});
            default: digit_code_s = 8'hFF;
        endcase
    end

    // Refresh divider and digit index; an/seg registered from the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r  <= 16'd0;
            digit_idx_r <= 3'd0;
            an_r        <= 8'hFE;
            seg_r       <= 8'hC0;
        end else begin
            if (scan_cnt_r == (REFRESH_DIV - 16'd1)) begin
                scan_cnt_r  <= 16'd0;
                digit_idx_r <= digit_idx_r + 3'd1;
            end else begin
                scan_cnt_r  <= scan_cnt_r + 16'd1;
                digit_idx_r <= digit_idx_r;
            end
            an_r  <= an_code_s;
            seg_r <= digit_code_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign data_valid = data_valid_r;
    assign seq_err    = seq_err_r;
    assign rx_count   = rx_count_r;

endmodule

// File: tb/tb_bus_display_rx.sv
// Scoreboard bench for bus_display_rx: expected data_valid cycles are queued at stimulus
// time and matched by a monitor; display contents are captured from the scan outputs.
module tb_bus_display_rx;

    logic        clk;
    logic        rst;
    logic [31:0] dataBus;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        data_valid;
    logic        seq_err;
    logic [7:0]  rx_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];

    bus_display_rx #(
        .TAG         (8'hAC),
        .REFRESH_DIV (16'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dataBus    (dataBus),
        .an         (an),
        .seg        (seg),
        .data_valid (data_valid),
        .seq_err    (seq_err),
        .rx_count   (rx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every data_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        int exp_cyc;
        if (!rst && data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dv_unexpected: data_valid high at cycle %0d, required low", cyc);
            end else begin
                exp_cyc = exp_q.pop_front();
                if (cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL dv_timing: data_valid at cycle %0d, required cycle %0d", cyc, exp_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a word one cycle later; off > 0 queues a data_valid expected off cycles after driving.
    task automatic send(input logic [31:0] w, input int off);
        tick(1);
        dataBus = w;
        if (off > 0) exp_q.push_back(cyc + off);
    endtask

    // Capture one full scan and compare all eight digits ({d7..d0} packed).
    task automatic check_display(input string name, input logic [63:0] exp);
        logic [7:0] got [8];
        logic [7:0] m;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        repeat (40) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                m = 8'b0000_0001 << j;
                if (an == ~m) got[j] = seg;
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_d%0d", name, i), {24'd0, got[i]}, {24'd0, exp[i*8 +: 8]});
        end
    endtask

    task automatic scan_test();
        logic [7:0] prev;
        int         last_chg;
        bit         have;
        bit         wrapped;
        prev     = an;
        last_chg = 0;
        have     = 1'b0;
        wrapped  = 1'b0;
        repeat (44) begin
            @(negedge clk);
            if (an !== prev) begin
                chk("scan_step", {24'd0, an}, {24'd0, prev[6:0], prev[7]});
                if (have) chk("scan_period", cyc - last_chg, 32'd4);
                if (prev == 8'h7F && an == 8'hFE) wrapped = 1'b1;
                have     = 1'b1;
                last_chg = cyc;
                prev     = an;
            end
        end
        chk("scan_wrap", {31'd0, wrapped}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        dataBus = 32'h0000_0000;
        tick(3);
        chk("rst_an", {24'd0, an}, 32'h0000_00FE);
        chk("rst_seg", {24'd0, seg}, 32'h0000_00C0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        chk("rst_rx_count", {24'd0, rx_count}, 32'd0);
        rst = 1'b0;

        scan_test();
        check_display("disp_reset", 64'hC0C0_FFC0_C0C0_C0C0);

        // seq 1, data 12345
        send(32'hAC02_3039, 17);
        tick(40);
        chk("w1_rx_count", {24'd0, rx_count}, 32'd1);
        chk("w1_seq_err", {31'd0, seq_err}, 32'd0);
        check_display("disp_12345", 64'hC0F9_FFF9_A4B0_9992);

        // seq 3 after seq 1: gap
        send(32'hAC06_0000, 17);
        tick(25);
        chk("w2_rx_count", {24'd0, rx_count}, 32'd2);
        chk("w2_seq_err", {31'd0, seq_err}, 32'd1);
        check_display("disp_seq3", 64'hC0B0_FFC0_C0C0_C0C0);

        // untagged and wrong-tag words are ignored
        send(32'h0000_0000, 0);
        tick(3);
        send(32'hAB02_3039, 0);
        tick(20);
        chk("notag_rx_count", {24'd0, rx_count}, 32'd2);

        // back-to-back words: second waits in the pending slot
        send(32'hAC0A_3FFF, 17);
        send(32'hAC0C_0001, 31);
        tick(40);
        chk("pend_rx_count", {24'd0, rx_count}, 32'd4);
        chk("pend_seq_err", {31'd0, seq_err}, 32'd1);
        check_display("disp_00001", 64'hC082_FFC0_C0C0_C0F9);

        // clear word
        send(32'hAC09_C000, 3);
        tick(10);
        chk("clr_seq_err", {31'd0, seq_err}, 32'd0);
        chk("clr_rx_count", {24'd0, rx_count}, 32'd5);
        check_display("disp_clear", 64'hC0C0_FFC0_C0C0_C0C0);

        // reset in the middle of a conversion
        send(32'hAC0A_3FFF, 0);
        tick(6);
        rst     = 1'b1;
        dataBus = 32'h0000_0000;
        #1;
        chk("mid_rst_an", {24'd0, an}, 32'h0000_00FE);
        chk("mid_rst_seg", {24'd0, seg}, 32'h0000_00C0);
        chk("mid_rst_dv", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_seq_err", {31'd0, seq_err}, 32'd0);
        chk("mid_rst_rx_count", {24'd0, rx_count}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check_display("disp_post_rst", 64'hC0C0_FFC0_C0C0_C0C0);
        chk("post_rst_rx_count", {24'd0, rx_count}, 32'd0);

        tick(5);
        chk("dv_all_seen", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
